// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the datapath.
//
// Fetches instructions over a level req/ack handshake and holds them in a
// small queue of {addr, inst} entries. The queue head goes to the datapath.
// A redirect flushes the queue. A fetch that is still outstanding when a
// redirect arrives runs to completion and its data is then dropped.
//
// Optional feature macro: FETCH_DROP_CNT_EN
//   When defined, adds the drop_cnt output. It counts discarded responses
//   and saturates at 255.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   pc           redirect target, used when pc_redirect=1
//   pc_redirect  taken branch/jump: flush and refetch from pc
//   advance      datapath consumes the head instruction
//   imem_req     fetch request, held until imem_ack
//   imem_addr    fetch address, stable while imem_req=1
//   imem_ack     memory response, sampled while imem_req=1
//   imem_rdata   returned instruction, valid with imem_ack
//   inst         queue head instruction (0 when empty)
//   inst_pc      queue head address (0 when empty)
//   inst_valid   queue non-empty
//   drop_cnt     discarded-response counter (FETCH_DROP_CNT_EN only)
//
// DEPTH must be 2 or 4. The queue pointers wrap by truncation, so DEPTH
// has to be a power of two.

module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 9,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_redirect,
  input  logic              advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid
`ifdef FETCH_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] fa_q;
  logic [ADDR_W-1:0] pend_q;
  logic              discard_q;
  logic [ADDR_W-1:0] q_addr_q [DEPTH];
  logic [INST_W-1:0] q_inst_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [CNT_W-1:0]  count_q;

  logic              ack_c;
  logic              push_c;
  logic              pop_c;
  logic [CNT_W-1:0]  count_d;
  logic [PTR_W-1:0]  wr_idx_c;

  always_comb begin
    ack_c  = (state_q == S_REQ) && imem_ack;
    // A redirect always flushes the queue, so it blocks both the pop and
    // the push on that edge.
    push_c = ack_c && !discard_q && !pc_redirect;
    pop_c  = advance && (count_q != '0) && !pc_redirect;
    count_d = count_q - CNT_W'(pop_c) + CNT_W'(push_c);
    // When the queue is full, count's low bits are zero, so the write slot
    // is the head slot that is being popped on the same edge.
    wr_idx_c = head_q + count_q[PTR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      fa_q      <= '0;
      pend_q    <= '0;
      discard_q <= 1'b0;
      head_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_inst_q[i] <= '0;
      end
    end else begin
      // queue
      if (pc_redirect) begin
        count_q <= '0;
      end else begin
        if (push_c) begin
          q_addr_q[wr_idx_c] <= fa_q;
          q_inst_q[wr_idx_c] <= imem_rdata;
        end
        if (pop_c) begin
          head_q <= head_q + PTR_W'(1);
        end
        count_q <= count_d;
      end

      // fetch FSM
      case (state_q)
        S_IDLE: begin
          if (pc_redirect) begin
            fa_q    <= pc;
            state_q <= S_REQ;
          end else if (count_q < FULL) begin
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_c) begin
            if (pc_redirect) begin
              fa_q      <= pc;
              discard_q <= 1'b0;
            end else if (discard_q) begin
              fa_q      <= pend_q;
              discard_q <= 1'b0;
            end else begin
              fa_q <= fa_q + ADDR_W'(1);
              if (count_d == FULL) begin
                state_q <= S_IDLE;
              end
            end
          end else if (pc_redirect) begin
            // The outstanding fetch must finish at its original address.
            // Hold the target until that fetch is acked.
            discard_q <= 1'b1;
            pend_q    <= pc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  logic       drop_c;

  always_comb begin
    drop_c = ack_c && (discard_q || pc_redirect);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (drop_c && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = fa_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? q_inst_q[head_q] : '0;
  assign inst_pc    = inst_valid ? q_addr_q[head_q] : '0;

endmodule
